// File: rtl/if_align_buffer.sv
// if_align_buffer: fetch-side instruction aligner for an RV32IMC pipeline.
// Fetches whole words from instruction memory and queues them as 16-bit parcels.
// Presents one complete instruction at a time to the ID stage.
// A compressed instruction is zero-extended; a 32-bit instruction may straddle a word.
module if_align_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_is_comp
);

  logic [15:0] r_buf [4];
  logic [2:0]  r_count;
  logic        r_outstanding;
  logic        r_stale;
  logic        r_skip_low;
  logic [31:0] r_fetch_ptr;
  logic [31:0] r_head_pc;

  logic        w_head_comp;
  logic        w_valid;
  logic        w_push_en;
  logic [1:0]  w_pop;
  logic [1:0]  w_push;
  logic [3:0]  w_level;
  logic [2:0]  w_base;
  logic [15:0] w_shift [4];
  logic [15:0] w_buf_next [4];

  // Decode the head parcel; a flush suppresses whatever is being presented.
  always_comb begin
    w_head_comp = (r_buf[0][1:0] != 2'b11);
    w_valid     = !flush && (((r_count != 3'd0) && w_head_comp) || (r_count >= 3'd2));
    id_valid    = w_valid;
    id_is_comp  = w_valid && w_head_comp;
    id_pc       = r_head_pc;
    id_inst     = 32'h0;
    if (w_valid) begin
      id_inst = w_head_comp ? {16'h0, r_buf[0]} : {r_buf[1], r_buf[0]};
    end
  end

  // Work out this cycle's pop and push sizes and the resulting fill level.
  // A new fetch needs room for a whole word after that level.
  always_comb begin
    w_pop = 2'd0;
    if (w_valid && id_ready) begin
      w_pop = w_head_comp ? 2'd1 : 2'd2;
    end
    w_push_en = imem_valid && !r_stale;
    w_push    = 2'd0;
    if (w_push_en) begin
      w_push = r_skip_low ? 2'd1 : 2'd2;
    end
    w_level    = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, w_push};
    w_base     = r_count - {1'b0, w_pop};
    fetch_req  = nrst && !flush && (!r_outstanding || imem_valid) && (w_level <= 4'd2);
    fetch_addr = r_fetch_ptr;
  end

  // Shift out the consumed parcels first, then append the arriving ones at the tail.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_shift[i] = 16'h0;
    end
    case (w_pop)
      2'd1: begin
        w_shift[0] = r_buf[1];
        w_shift[1] = r_buf[2];
        w_shift[2] = r_buf[3];
      end
      2'd2: begin
        w_shift[0] = r_buf[2];
        w_shift[1] = r_buf[3];
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          w_shift[i] = r_buf[i];
        end
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      w_buf_next[i] = w_shift[i];
      if (w_push_en) begin
        if (r_skip_low) begin
          if (3'(i) == w_base) w_buf_next[i] = imem_rdata[31:16];
        end else begin
          if (3'(i) == w_base) begin
            w_buf_next[i] = imem_rdata[15:0];
          end else if (3'(i) == w_base + 3'd1) begin
            w_buf_next[i] = imem_rdata[31:16];
          end
        end
      end
    end
  end

  // State update. A flush overrides consume and refill in the same cycle.
  // A response still in flight across a flush is marked stale and dropped when it lands.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 4; i++) begin
        r_buf[i] <= 16'h0;
      end
      r_count       <= 3'd0;
      r_outstanding <= 1'b0;
      r_stale       <= 1'b0;
      r_skip_low    <= 1'b0;
      r_fetch_ptr   <= RESET_PC & ~32'h3;
      r_head_pc     <= RESET_PC;
    end else if (flush) begin
      for (int i = 0; i < 4; i++) begin
        r_buf[i] <= 16'h0;
      end
      r_count       <= 3'd0;
      r_head_pc     <= flush_pc;
      r_fetch_ptr   <= {flush_pc[31:2], 2'b00};
      r_skip_low    <= flush_pc[1];
      r_outstanding <= r_outstanding && !imem_valid;
      r_stale       <= r_outstanding && !imem_valid;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_buf[i] <= w_buf_next[i];
      end
      r_count   <= w_level[2:0];
      r_head_pc <= r_head_pc + {29'b0, w_pop, 1'b0};
      if (w_push_en && r_skip_low) begin
        r_skip_low <= 1'b0;
      end
      if (fetch_req) begin
        r_fetch_ptr   <= r_fetch_ptr + 32'd4;
        r_outstanding <= 1'b1;
      end else if (imem_valid) begin
        r_outstanding <= 1'b0;
      end
      if (imem_valid) begin
        r_stale <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_align_buffer.sv
// Testbench for if_align_buffer.
// A one-cycle-latency memory model answers fetches.
// Per-cycle vector tables give the expected ID and fetch outputs.
module tb_if_align_buffer;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        flush;
  logic [31:0] flushPc;
  logic        fetchReq;
  logic [31:0] fetchAddr;
  logic [31:0] imemRdata;
  logic        imemValid;
  logic        idReady;
  logic        idValid;
  logic [31:0] idInst;
  logic [31:0] idPc;
  logic        idIsComp;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] mem [0:255];
  logic        memReq;
  logic [31:0] memAddr;

  typedef struct {
    logic        idReady;
    logic        flush;
    logic [31:0] flushPc;
    logic        expValid;
    logic [31:0] expInst;
    logic [31:0] expPc;
    logic        expComp;
    logic        expReq;
    logic [31:0] expAddr;
  } vec_t;

  vec_t vecs[$];

  if_align_buffer #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .flush      (flush),
    .flush_pc   (flushPc),
    .fetch_req  (fetchReq),
    .fetch_addr (fetchAddr),
    .imem_rdata (imemRdata),
    .imem_valid (imemValid),
    .id_ready   (idReady),
    .id_valid   (idValid),
    .id_inst    (idInst),
    .id_pc      (idPc),
    .id_is_comp (idIsComp)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic f, input logic [31:0] fp,
                              input logic v, input logic [31:0] inst, input logic [31:0] pc,
                              input logic c, input logic q, input logic [31:0] a);
    vec_t t;
    t.idReady = r; t.flush = f; t.flushPc = fp;
    t.expValid = v; t.expInst = inst; t.expPc = pc; t.expComp = c;
    t.expReq = q; t.expAddr = a;
    return t;
  endfunction

  // Straight-line stream word k = addi x0, x0, k (distinct per address).
  function automatic logic [31:0] streamWord(input int k);
    return 32'h0000_0013 | (32'(k) << 20);
  endfunction

  task automatic fillConst(input logic [31:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  task automatic fillStream();
    for (int i = 0; i < 256; i++) mem[i] = streamWord(i);
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkVal({tag, " id_valid"}, 32'(idValid), 32'(v.expValid));
    checkVal({tag, " id_inst"}, idInst, v.expInst);
    checkVal({tag, " id_is_comp"}, 32'(idIsComp), 32'(v.expComp));
    checkVal({tag, " fetch_req"}, 32'(fetchReq), 32'(v.expReq));
    checkVal({tag, " fetch_addr"}, fetchAddr, v.expAddr);
    if (v.expValid) checkVal({tag, " id_pc"}, idPc, v.expPc);
  endtask

  // One cycle: starts 1 time unit after a rising edge, drives inputs,
  // checks at the falling edge, records any fetch for the memory model.
  task automatic applyStimulus(input vec_t v, input string tag);
    imemValid = memReq;
    imemRdata = memReq ? mem[memAddr[9:2]] : 32'h0;
    idReady   = v.idReady;
    flush     = v.flush;
    flushPc   = v.flushPc;
    @(negedge clk);
    checkOutput(v, tag);
    memReq  = fetchReq;
    memAddr = fetchAddr;
    @(posedge clk);
    #1;
  endtask

  task automatic runTable(input string tag);
    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("%s c%0d", tag, i + 1));
  endtask

  // Asynchronous reset: outputs must clear with no clock edge, then release after two edges.
  task automatic doReset(input string tag);
    if (nrst !== 1'b1) begin
      nrst = 1'b1;
      #1;
    end
    nrst      = 1'b0;
    flush     = 1'b0;
    flushPc   = 32'h0;
    idReady   = 1'b1;
    imemValid = 1'b0;
    imemRdata = 32'h0;
    memReq    = 1'b0;
    memAddr   = 32'h0;
    #1;
    checkVal({tag, " rst id_valid"}, 32'(idValid), 32'd0);
    checkVal({tag, " rst id_inst"}, idInst, 32'h0);
    checkVal({tag, " rst id_is_comp"}, 32'(idIsComp), 32'd0);
    checkVal({tag, " rst fetch_req"}, 32'(fetchReq), 32'd0);
    checkVal({tag, " rst fetch_addr"}, fetchAddr, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    // Straight-line 32-bit stream at one instruction per cycle
    fillConst(32'h0000_0013);
    doReset("stream");
    vecs.delete();
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,  0, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,  0, 0, 1, 32'h4));
    vecs.push_back(mk(1, 0, 0, 1, 32'h13, 0, 0, 1, 32'h8));
    vecs.push_back(mk(1, 0, 0, 1, 32'h13, 4, 0, 1, 32'hC));
    vecs.push_back(mk(1, 0, 0, 1, 32'h13, 8, 0, 1, 32'h10));
    runTable("stream");

    // Two compressed parcels in one word; the buffer fills and fetch pauses
    fillConst(32'h0000_0013);
    mem[0] = 32'h4505_0001;
    doReset("comp");
    vecs.delete();
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,    0, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,    0, 0, 1, 32'h4));
    vecs.push_back(mk(1, 0, 0, 1, 32'h1,    0, 1, 0, 32'h8));
    vecs.push_back(mk(1, 0, 0, 1, 32'h4505, 2, 1, 1, 32'h8));
    vecs.push_back(mk(1, 0, 0, 1, 32'h13,   4, 0, 1, 32'hC));
    runTable("comp");

    // 32-bit instruction straddling a word boundary
    fillConst(32'h0000_0013);
    mem[0] = 32'h0013_0001;
    mem[1] = 32'h0001_0000;
    doReset("straddle");
    vecs.delete();
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,  0, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,  0, 0, 1, 32'h4));
    vecs.push_back(mk(1, 0, 0, 1, 32'h1,  0, 1, 0, 32'h8));
    vecs.push_back(mk(1, 0, 0, 1, 32'h13, 2, 0, 1, 32'h8));
    vecs.push_back(mk(1, 0, 0, 1, 32'h1,  6, 1, 1, 32'hC));
    runTable("straddle");

    // Five-cycle ID stall: outputs hold, fetch stops at a full buffer, no loss or repeat
    fillStream();
    doReset("stall");
    vecs.delete();
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,          0, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,          0, 0, 1, 32'h4));
    vecs.push_back(mk(1, 0, 0, 1, streamWord(0),  0, 0, 1, 32'h8));
    vecs.push_back(mk(1, 0, 0, 1, streamWord(1),  4, 0, 1, 32'hC));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 1, streamWord(2), 8, 0, 0, 32'h10));
    vecs.push_back(mk(1, 0, 0, 1, streamWord(2),  8, 0, 1, 32'h10));
    vecs.push_back(mk(1, 0, 0, 1, streamWord(3), 12, 0, 1, 32'h14));
    vecs.push_back(mk(1, 0, 0, 1, streamWord(4), 16, 0, 1, 32'h18));
    vecs.push_back(mk(1, 0, 0, 1, streamWord(5), 20, 0, 1, 32'h1C));
    runTable("stall");

    // Flush to a halfword target while a response is in flight.
    // The in-flight word is dropped and the low parcel of 0x100 is skipped.
    // The 32-bit instruction at 0x102 under-runs until 0x104 lands.
    fillStream();
    mem[64] = 32'h5093_BEEF;
    mem[65] = 32'h4505_1234;
    mem[66] = 32'h0000_0013;
    mem[67] = 32'h0000_0013;
    doReset("flush");
    vecs.delete();
    vecs.push_back(mk(1, 0, 0,           0, 32'h0,         0,     0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0,           0, 32'h0,         0,     0, 1, 32'h4));
    vecs.push_back(mk(1, 0, 0,           1, streamWord(0), 0,     0, 1, 32'h8));
    vecs.push_back(mk(1, 1, 32'h102,     0, 32'h0,         0,     0, 0, 32'hC));
    vecs.push_back(mk(1, 0, 0,           0, 32'h0,         0,     0, 1, 32'h100));
    vecs.push_back(mk(1, 0, 0,           0, 32'h0,         0,     0, 1, 32'h104));
    vecs.push_back(mk(1, 0, 0,           0, 32'h0,         0,     0, 0, 32'h108));
    vecs.push_back(mk(1, 0, 0,           1, 32'h1234_5093, 32'h102, 0, 1, 32'h108));
    vecs.push_back(mk(1, 0, 0,           1, 32'h4505,      32'h106, 1, 1, 32'h10C));
    vecs.push_back(mk(1, 0, 0,           1, 32'h13,        32'h108, 0, 1, 32'h110));
    runTable("flush");

    // Asynchronous reset dropped mid-stream, then a clean restart from RESET_PC
    fillStream();
    doReset("async pre");
    vecs.delete();
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         0, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         0, 0, 1, 32'h4));
    vecs.push_back(mk(1, 0, 0, 1, streamWord(0), 0, 0, 1, 32'h8));
    runTable("async run");
    #1;
    checkVal("async mid-stream id_valid", 32'(idValid), 32'd1);
    doReset("async");
    runTable("async restart");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
